// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types and frame constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic wr, rd;
  always_comb begin
    full = level_q == (AW+1)'(DEPTH);
    empty = level_q == '0;
    rd = pop && !empty;
    wr = push && (!full || rd);
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(rd);
    level_d = level_q + (AW+1)'(wr) - (AW+1)'(rd);
    dout = mem_q[rd_ptr_q];
    level = level_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampled 8N1 receiver feeding a byte FIFO with
// framing/overrun error pulses.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          rx_pad_i,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [7:0]                    m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun_err
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  rx_state_e state_q, state_d;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic armed_q, armed_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rx_s, tick, last, push, pop, full, empty;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_pad_i};
    rx_s = sync_q[SYNC_STAGES-1];
    tick = state_q != IDLE && tick_cnt_q == baud_div;
    tick_cnt_d = (state_q == IDLE || tick) ? '0 : tick_cnt_q + DIV_W'(1);
    last = samp_q == 4'(OVERSAMPLE-1);
    state_d = state_q;
    samp_d = tick ? samp_q + 4'd1 : samp_q;
    bit_d = bit_q;
    shreg_d = shreg_q;
    // After a bad stop bit the line must go idle before a new start is accepted
    armed_d = armed_q | rx_s;
    push = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s && armed_q) begin
        state_d = START;
        samp_d = '0;
      end
      START: if (tick && samp_q == 4'(MID_SAMPLE)) begin
        state_d = rx_s ? IDLE : DATA;
        samp_d = '0;
        bit_d = '0;
      end
      DATA: if (tick && last) begin
        shreg_d[bit_q] = rx_s;
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'(DATA_BITS-1) ? STOP : DATA;
      end
      STOP: if (tick && last) begin
        push = rx_s;
        frame_err_d = !rx_s;
        armed_d = rx_s;
        state_d = IDLE;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
      push = 1'b0;
      frame_err_d = 1'b0;
    end
    m_valid = !empty;
    pop = m_valid && m_ready;
    overrun_d = push && full && !pop;
    frame_err = frame_err_q;
    overrun_err = overrun_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      tick_cnt_q <= '0;
      state_q <= IDLE;
      samp_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      armed_q <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      state_q <= state_d;
      samp_q <= samp_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shreg_q),
    .pop   (pop),
    .dout  (m_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed 8N1 frames against hand-computed bytes, levels and error pulses
module tb_uart_rx_frontend;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic [15:0] baud_div = 16'd0;
  logic rx = 1'b1;
  logic m_valid, m_ready = 1'b0;
  logic [7:0] m_data;
  logic [3:0] fifo_level;
  logic frame_err, overrun_err;
  int checks = 0, failures = 0;
  int ferr_cnt = 0, ovr_cnt = 0, fb, ob;
  logic mon_en = 1'b0;
  int pop_n, run, maxrun, maxlvl;
  logic [7:0] pops [8];
  uart_rx_frontend dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .baud_div    (baud_div),
    .rx_pad_i    (rx),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .fifo_level  (fifo_level),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun_err) ovr_cnt++;
    if (!mon_en) begin
      pop_n = 0; run = 0; maxrun = 0; maxlvl = 0;
    end else begin
      if (m_valid && m_ready && pop_n < 8) begin
        pops[pop_n] = m_data;
        pop_n++;
      end
      run = m_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] b, logic stop, int cpb);
    rx = 1'b0;
    cyc(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(cpb);
    end
    rx = stop;
    cyc(cpb);
    rx = 1'b1;
  endtask
  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 20 && m_valid; i++) cyc(1);
    m_ready = 1'b0;
  endtask
  initial begin
    cyc(3);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun_err), 0);
    rst_n = 1'b1;
    cyc(5);
    // 1: single good frame
    fb = ferr_cnt; ob = ovr_cnt;
    send(8'hA5, 1'b1, 16);
    cyc(2);
    check("t1_valid", 32'(m_valid), 1);
    check("t1_data", 32'(m_data), 32'hA5);
    check("t1_level", 32'(fifo_level), 1);
    check("t1_errs", 32'(ferr_cnt - fb + ovr_cnt - ob), 0);
    drain();
    // 2: false start glitch
    fb = ferr_cnt;
    rx = 1'b0; cyc(4); rx = 1'b1; cyc(40);
    check("t2_state", 32'(dut.state_q), 0);
    check("t2_level", 32'(fifo_level), 0);
    check("t2_ferr", 32'(ferr_cnt - fb), 0);
    // 3: bad stop bit followed by a held-low break, then a good frame
    fb = ferr_cnt;
    send(8'h3C, 1'b0, 16);
    rx = 1'b0; cyc(48); rx = 1'b1; cyc(16);
    check("t3_ferr", 32'(ferr_cnt - fb), 1);
    check("t3_level0", 32'(fifo_level), 0);
    send(8'h5A, 1'b1, 16);
    cyc(4);
    check("t3_data", 32'(m_data), 32'h5A);
    check("t3_level1", 32'(fifo_level), 1);
    drain();
    // 4: overflow then ordered drain
    ob = ovr_cnt;
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 16);
    cyc(4);
    check("t4_level", 32'(fifo_level), 8);
    check("t4_ovr", 32'(ovr_cnt - ob), 1);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t4_pop_valid", 32'(m_valid), 1);
      check("t4_pop_data", 32'(m_data), 32'(i));
      cyc(1);
    end
    @(negedge clk);
    check("t4_empty", 32'(m_valid), 0);
    m_ready = 1'b0;
    // 5: async reset in the middle of bit 3
    send(8'h77, 1'b1, 16);
    cyc(4);
    check("t5_pre_level", 32'(fifo_level), 1);
    rx = 1'b0; cyc(16);
    rx = 1'b1; cyc(48);
    rx = 1'b0; cyc(8);
    check("t5_in_data", 32'(dut.state_q), 2);
    check("t5_bit3", 32'(dut.bit_q), 3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(m_valid), 0);
    check("t5_data", 32'(m_data), 0);
    check("t5_level", 32'(fifo_level), 0);
    check("t5_errs", 32'({frame_err, overrun_err}), 0);
    cyc(3);
    rst_n = 1'b1; rx = 1'b1;
    cyc(20);
    send(8'hC3, 1'b1, 16);
    cyc(4);
    check("t5_c3", 32'(m_data), 32'hC3);
    check("t5_c3_level", 32'(fifo_level), 1);
    drain();
    // 6: 115200-style divisor, back-to-back frames, consumer always ready
    baud_div = 16'd13;
    m_ready = 1'b1;
    mon_en = 1'b1;
    cyc(1);
    send(8'h00, 1'b1, 224);
    send(8'hFF, 1'b1, 224);
    send(8'h55, 1'b1, 224);
    cyc(20);
    check("t6_count", 32'(pop_n), 3);
    check("t6_d0", 32'(pops[0]), 32'h00);
    check("t6_d1", 32'(pops[1]), 32'hFF);
    check("t6_d2", 32'(pops[2]), 32'h55);
    check("t6_pulse", 32'(maxrun), 1);
    check("t6_maxlvl", 32'(maxlvl), 1);
    mon_en = 1'b0;
    m_ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
